// File: rtl/ram_1w_1rs_wf.sv
// Single-clock simple-dual-port RAM: lane-masked write port, synchronous read port with
// selectable read-under-write policy, optional output register and a post-reset clear sweep.
module ram_1w_1rs_wf #(
   parameter int unsigned            WORD_COUNT       = 256,
   parameter int unsigned            WORD_WIDTH       = 32,
   parameter int unsigned            MASK_WIDTH       = 4,
   parameter string                  READ_UNDER_WRITE = "writeFirst",
   parameter int unsigned            OUT_REG          = 0,
   parameter int unsigned            CLEAR_ON_RESET   = 1,
   parameter logic [WORD_WIDTH-1:0]  CLEAR_VALUE      = '0,
   localparam int unsigned           ADDR_WIDTH       = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1
) (
   input  logic                   clk,
   input  logic                   resetn,
   output logic                   ready,
   input  logic                   wr_en,
   input  logic [MASK_WIDTH-1:0]  wr_mask,
   input  logic [ADDR_WIDTH-1:0]  wr_addr,
   input  logic [WORD_WIDTH-1:0]  wr_data,
   input  logic                   rd_en,
   input  logic [ADDR_WIDTH-1:0]  rd_addr,
   output logic [WORD_WIDTH-1:0]  rd_data,
   output logic                   rd_valid
);

   localparam int unsigned           LANE        = WORD_WIDTH / MASK_WIDTH;
   localparam bit                    WRITE_FIRST = (READ_UNDER_WRITE == "writeFirst");
   localparam logic [ADDR_WIDTH:0]   DEPTH       = (ADDR_WIDTH + 1)'(WORD_COUNT);
   localparam logic [ADDR_WIDTH-1:0] LAST        = ADDR_WIDTH'(WORD_COUNT - 1);

   if ((WORD_WIDTH % MASK_WIDTH) != 0) begin : g_bad_mask
      $error("ram_1w_1rs_wf: MASK_WIDTH must divide WORD_WIDTH");
   end
   if ((READ_UNDER_WRITE != "writeFirst") && (READ_UNDER_WRITE != "readFirst")) begin : g_bad_ruw
      $error("ram_1w_1rs_wf: READ_UNDER_WRITE must be writeFirst or readFirst");
   end

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t                  r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_clr_cnt, w_clr_cnt_nxt;
   logic                    w_clr_we;
   logic                    r_ready;
   logic [WORD_WIDTH-1:0]   r_mem [WORD_COUNT];
   logic                    w_wr_in_range, w_rd_in_range, w_wr_fire, w_rd_fire;
   logic [WORD_WIDTH-1:0]   w_rd_word;
   logic [WORD_WIDTH-1:0]   r_rd_data_p0;
   logic                    r_vld_p0;

   function automatic logic [WORD_WIDTH-1:0] f_merge_lanes(
      input logic [WORD_WIDTH-1:0] old_word,
      input logic [WORD_WIDTH-1:0] new_word,
      input logic [MASK_WIDTH-1:0] mask
   );
      logic [WORD_WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < MASK_WIDTH; i++) begin
         if (mask[i]) res[i*LANE +: LANE] = new_word[i*LANE +: LANE];
      end
      return res;
   endfunction

   // ready is registered so it reads 0 throughout reset, even when no sweep is configured
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
         r_clr_cnt <= '0;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
         r_ready   <= (w_state_nxt == S_RUN);
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      w_clr_we      = 1'b0;
      case (r_state)
         S_CLEAR: begin
            w_clr_we      = 1'b1;
            w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            if (r_clr_cnt == LAST) begin
               w_state_nxt   = S_RUN;
               w_clr_cnt_nxt = '0;
            end
         end
         default: ;
      endcase
   end

   assign ready         = r_ready;
   assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH);
   assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH);
   assign w_wr_fire     = r_ready & wr_en & w_wr_in_range;
   assign w_rd_fire     = r_ready & rd_en;

   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_clr_cnt] <= CLEAR_VALUE;
      end else if (w_wr_fire) begin
         for (int i = 0; i < MASK_WIDTH; i++) begin
            if (wr_mask[i]) r_mem[wr_addr][i*LANE +: LANE] <= wr_data[i*LANE +: LANE];
         end
      end
   end

   // out-of-range reads return zero; a colliding in-range write can never be out of range
   always_comb begin
      w_rd_word = w_rd_in_range ? r_mem[rd_addr] : '0;
      if (WRITE_FIRST && w_wr_fire && (wr_addr == rd_addr)) begin
         w_rd_word = f_merge_lanes(w_rd_word, wr_data, wr_mask);
      end
   end

   // stage p0: array read, data held between reads
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rd_data_p0 <= '0;
         r_vld_p0     <= 1'b0;
      end else begin
         r_vld_p0 <= w_rd_fire;
         if (w_rd_fire) r_rd_data_p0 <= w_rd_word;
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [WORD_WIDTH-1:0] r_rd_data_p1;
      logic                  r_vld_p1;

      // stage p1: optional output register
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            r_rd_data_p1 <= '0;
            r_vld_p1     <= 1'b0;
         end else begin
            r_vld_p1 <= r_vld_p0;
            if (r_vld_p0) r_rd_data_p1 <= r_rd_data_p0;
         end
      end

      assign rd_data  = r_rd_data_p1;
      assign rd_valid = r_vld_p1;
   end else begin : g_no_out_reg
      assign rd_data  = r_rd_data_p0;
      assign rd_valid = r_vld_p0;
   end

endmodule

// File: tb/tb_ram_1w_1rs_wf.sv
// Bench for ram_1w_1rs_wf: two configurations (256/writeFirst/latency 1 and 100/readFirst/latency 2)
// checked every cycle against a behavioural model, plus hand-computed scenario checks.
module tb_ram_1w_1rs_wf;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // configuration A: 256 words, writeFirst, no output register
   logic        rstn_a = 1'b0;
   logic        ready_a, wr_en_a, rd_en_a, rd_valid_a;
   logic [3:0]  wr_mask_a;
   logic [7:0]  wr_addr_a, rd_addr_a;
   logic [31:0] wr_data_a, rd_data_a;

   // configuration B: 100 words, readFirst, output register
   logic        rstn_b = 1'b0;
   logic        ready_b, wr_en_b, rd_en_b, rd_valid_b;
   logic [3:0]  wr_mask_b;
   logic [6:0]  wr_addr_b, rd_addr_b;
   logic [31:0] wr_data_b, rd_data_b;

   ram_1w_1rs_wf #(
      .WORD_COUNT(256), .WORD_WIDTH(32), .MASK_WIDTH(4), .READ_UNDER_WRITE("writeFirst"),
      .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)
   ) u_a (
      .clk(clk), .resetn(rstn_a), .ready(ready_a),
      .wr_en(wr_en_a), .wr_mask(wr_mask_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
      .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
   );

   ram_1w_1rs_wf #(
      .WORD_COUNT(100), .WORD_WIDTH(32), .MASK_WIDTH(4), .READ_UNDER_WRITE("readFirst"),
      .OUT_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)
   ) u_b (
      .clk(clk), .resetn(rstn_b), .ready(ready_b),
      .wr_en(wr_en_b), .wr_mask(wr_mask_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
      .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
      return r;
   endfunction

   // behavioural model A: outputs visible one edge after the read request
   logic [31:0] mem_a [256];
   int          ma_clr   = 0;
   logic        ma_ready = 1'b0;
   logic        ma_vld   = 1'b0;
   logic [31:0] ma_data  = '0;

   initial forever begin
      @(posedge clk or negedge rstn_a);
      if (!rstn_a) begin
         ma_clr = 0; ma_ready = 1'b0; ma_vld = 1'b0; ma_data = '0;
      end else if (!ma_ready) begin
         mem_a[ma_clr] = '0;
         ma_clr++;
         ma_ready = (ma_clr == 256);
         ma_vld   = 1'b0;
      end else begin
         ma_vld = rd_en_a;
         if (rd_en_a) begin
            ma_data = mem_a[rd_addr_a];
            if (wr_en_a && wr_addr_a == rd_addr_a) ma_data = merge(ma_data, wr_data_a, wr_mask_a);
         end
         if (wr_en_a) mem_a[wr_addr_a] = merge(mem_a[wr_addr_a], wr_data_a, wr_mask_a);
      end
   end

   // behavioural model B: one pending slot delays results by a second edge
   logic [31:0] mem_b [100];
   int          mb_clr      = 0;
   logic        mb_ready    = 1'b0;
   logic        mb_pend_vld = 1'b0;
   logic [31:0] mb_pend     = '0;
   logic        mb_vld      = 1'b0;
   logic [31:0] mb_data     = '0;

   initial forever begin
      @(posedge clk or negedge rstn_b);
      if (!rstn_b) begin
         mb_clr = 0; mb_ready = 1'b0; mb_pend_vld = 1'b0; mb_pend = '0;
         mb_vld = 1'b0; mb_data = '0;
      end else begin
         mb_vld = mb_pend_vld;
         if (mb_pend_vld) mb_data = mb_pend;
         mb_pend_vld = 1'b0;
         if (!mb_ready) begin
            mem_b[mb_clr] = '0;
            mb_clr++;
            mb_ready = (mb_clr == 100);
         end else begin
            if (rd_en_b) begin
               mb_pend_vld = 1'b1;
               mb_pend     = (int'(rd_addr_b) < 100) ? mem_b[rd_addr_b] : '0;
            end
            if (wr_en_b && int'(wr_addr_b) < 100)
               mem_b[wr_addr_b] = merge(mem_b[wr_addr_b], wr_data_b, wr_mask_b);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      #1;
      check("A_ready", 32'(ready_a), 32'(ma_ready));
      check("A_rd_valid", 32'(rd_valid_a), 32'(ma_vld));
      check("A_rd_data", rd_data_a, ma_data);
      check("B_ready", 32'(ready_b), 32'(mb_ready));
      check("B_rd_valid", 32'(rd_valid_b), 32'(mb_vld));
      check("B_rd_data", rd_data_b, mb_data);
   end

   task automatic op_a(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                       input logic [3:0] wm, input logic re, input logic [7:0] ra);
      @(negedge clk);
      wr_en_a = we; wr_addr_a = wa; wr_data_a = wd; wr_mask_a = wm;
      rd_en_a = re; rd_addr_a = ra;
   endtask

   task automatic op_b(input logic we, input logic [6:0] wa, input logic [31:0] wd,
                       input logic [3:0] wm, input logic re, input logic [6:0] ra);
      @(negedge clk);
      wr_en_b = we; wr_addr_b = wa; wr_data_b = wd; wr_mask_b = wm;
      rd_en_b = re; rd_addr_b = ra;
   endtask

   initial begin
      int n;
      // requests during reset and sweep must be ignored
      wr_en_a = 1'b1; wr_addr_a = 8'd3; wr_data_a = 32'hFFFF_FFFF; wr_mask_a = 4'hF;
      rd_en_a = 1'b1; rd_addr_a = 8'd3;
      wr_en_b = 1'b1; wr_addr_b = 7'd3; wr_data_b = 32'hFFFF_FFFF; wr_mask_b = 4'hF;
      rd_en_b = 1'b1; rd_addr_b = 7'd3;

      // T1: clear sweep length and contents
      repeat (3) @(negedge clk);
      rstn_a = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ready_a && n < 400);
      check("T1_clear_cycles", 32'(n), 32'd256);
      wr_en_a = 1'b0; rd_en_a = 1'b0;
      for (int i = 0; i < 256; i++) op_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'(i));
      op_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);

      // T2: masked partial write
      op_a(1'b1, 8'd5, 32'h1122_3344, 4'hF, 1'b0, 8'd0);
      op_a(1'b1, 8'd5, 32'hAABB_CCDD, 4'b0101, 1'b0, 8'd0);
      op_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd5);
      @(posedge clk); #1;
      check("T2_masked", rd_data_a, 32'h11BB_33DD);

      // T3: writeFirst collision, then read-after-write
      op_a(1'b1, 8'd7, 32'h0, 4'hF, 1'b0, 8'd0);
      op_a(1'b1, 8'd7, 32'hFFFF_FFFF, 4'b0011, 1'b1, 8'd7);
      @(posedge clk); #1;
      check("T3_write_first", rd_data_a, 32'h0000_FFFF);
      op_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd7);
      @(posedge clk); #1;
      check("T3_after_write_A", rd_data_a, 32'h0000_FFFF);

      repeat (1500) begin
         @(negedge clk);
         wr_en_a   = 1'($urandom_range(0, 1));
         wr_addr_a = 8'($urandom_range(0, 15));
         wr_data_a = $urandom;
         wr_mask_a = 4'($urandom);
         rd_en_a   = 1'($urandom_range(0, 1));
         rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr_a : 8'($urandom_range(0, 15));
      end

      // T6 on A: reset clears held output at once
      op_a(1'b1, 8'd2, 32'hCAFE_F00D, 4'hF, 1'b0, 8'd0);
      op_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd2);
      @(posedge clk); #1;
      check("T6A_pre_data", rd_data_a, 32'hCAFE_F00D);
      rstn_a = 1'b0;
      #1;
      check("T6A_data_zero", rd_data_a, 32'h0);
      check("T6A_valid_zero", 32'(rd_valid_a), 32'h0);
      op_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);

      // T5: reset at clear cycle 50 restarts the 100-word sweep
      @(negedge clk);
      rstn_b = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      check("T5_ready_mid_clear", 32'(ready_b), 32'h0);
      @(negedge clk);
      rstn_b = 1'b0;
      repeat (2) @(negedge clk);
      rstn_b = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ready_b && n < 400);
      check("T5_clear_cycles", 32'(n), 32'd100);
      wr_en_b = 1'b0; rd_en_b = 1'b0;

      // T3 readFirst: whole old word
      op_b(1'b1, 7'd7, 32'h0, 4'hF, 1'b0, 7'd0);
      op_b(1'b1, 7'd7, 32'hFFFF_FFFF, 4'b0011, 1'b1, 7'd7);
      op_b(1'b0, 7'd0, 32'd0, 4'd0, 1'b0, 7'd0);
      @(posedge clk); #1;
      check("T3_read_first_vld", 32'(rd_valid_b), 32'h1);
      check("T3_read_first", rd_data_b, 32'h0);
      op_b(1'b0, 7'd0, 32'd0, 4'd0, 1'b1, 7'd7);
      op_b(1'b0, 7'd0, 32'd0, 4'd0, 1'b0, 7'd0);
      @(posedge clk); #1;
      check("T3_after_write_B", rd_data_b, 32'h0000_FFFF);

      // T4: back-to-back reads through the output register
      for (int i = 0; i < 4; i++) op_b(1'b1, 7'(i), 32'(10 + i), 4'hF, 1'b0, 7'd0);
      op_b(1'b0, 7'd0, 32'd0, 4'd0, 1'b0, 7'd0);
      for (int i = 0; i < 6; i++) begin
         if (i < 4) op_b(1'b0, 7'd0, 32'd0, 4'd0, 1'b1, 7'(i));
         else       op_b(1'b0, 7'd0, 32'd0, 4'd0, 1'b0, 7'd0);
         @(posedge clk); #1;
         check("T4_valid", 32'(rd_valid_b), (i >= 1 && i <= 4) ? 32'h1 : 32'h0);
         if (i >= 1 && i <= 4) check("T4_data", rd_data_b, 32'(9 + i));
      end

      // T5: out-of-range write dropped, read returns zero with valid
      op_b(1'b1, 7'd120, 32'hDEAD_BEEF, 4'hF, 1'b0, 7'd0);
      op_b(1'b0, 7'd0, 32'd0, 4'd0, 1'b1, 7'd120);
      op_b(1'b0, 7'd0, 32'd0, 4'd0, 1'b0, 7'd0);
      @(posedge clk); #1;
      check("T5_oor_valid", 32'(rd_valid_b), 32'h1);
      check("T5_oor_data", rd_data_b, 32'h0);

      repeat (1500) begin
         @(negedge clk);
         wr_en_b   = 1'($urandom_range(0, 1));
         wr_addr_b = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(90, 127));
         wr_data_b = $urandom;
         wr_mask_b = 4'($urandom);
         rd_en_b   = 1'($urandom_range(0, 1));
         rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr_b :
                     (($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(90, 127)));
      end

      // T6 on B: read in flight is dropped by reset
      op_b(1'b1, 7'd3, 32'h1234_5678, 4'hF, 1'b0, 7'd0);
      op_b(1'b0, 7'd0, 32'd0, 4'd0, 1'b1, 7'd3);
      @(posedge clk); #1;
      rstn_b = 1'b0;
      #1;
      check("T6B_data_zero", rd_data_b, 32'h0);
      check("T6B_valid_zero", 32'(rd_valid_b), 32'h0);
      op_b(1'b0, 7'd0, 32'd0, 4'd0, 1'b0, 7'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("T6B_no_valid", 32'(rd_valid_b), 32'h0);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
